// File: rtl/shift_rows_unit_if.sv
// Handshake bundle for shift_rows_unit: the input block stream, the result stream and the
// FIFO fill level.
interface shift_rows_unit_if #(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic               in_inv;
    logic [TAG_W-1:0]   in_tag;
    logic [0:32*NB-1]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [TAG_W-1:0]   out_tag;
    logic [0:32*NB-1]   out_data;
    logic [1:0]         occupancy;

    // Producer/consumer side
    modport master (
        output in_valid, in_inv, in_tag, in_data, out_ready,
        input  in_ready, out_valid, out_tag, out_data, occupancy
    );

    // The unit itself
    modport slave (
        input  in_valid, in_inv, in_tag, in_data, out_ready,
        output in_ready, out_valid, out_tag, out_data, occupancy
    );
endinterface

// File: rtl/shift_rows_unit.sv
// Rijndael ShiftRows / InvShiftRows on an NB-column state, followed by a 2-entry result FIFO.
// The permutation is pure wiring selected per block by in_inv; the FIFO gives one cycle latency.
module shift_rows_unit #(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    shift_rows_unit_if.slave bus
);
    localparam int unsigned W = 32 * NB;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_unit: NB must be 4, 6 or 8");
    end

    logic [0:W-1] fwd_data;
    logic [0:W-1] inv_data;
    logic [0:W-1] perm_data;

    // Byte (r,c) sits at bits [8*(4c+r) +: 8]; rows rotate left (fwd) or right (inv).
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int Off    = (r == 0) ? 0 : (r == 1) ? 1 : (NB == 8) ? r + 1 : r;
            localparam int FwdSrc = (c + Off) % NB;
            localparam int InvSrc = (c + NB - Off) % NB;
            assign fwd_data[8*(4*c+r) +: 8] = bus.in_data[8*(4*FwdSrc+r) +: 8];
            assign inv_data[8*(4*c+r) +: 8] = bus.in_data[8*(4*InvSrc+r) +: 8];
        end
    end

    assign perm_data = bus.in_inv ? inv_data : fwd_data;

    logic [0:W-1]     data_q [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             live_q;   // low until the first edge after reset release
    logic             push;
    logic             pop;

    // in_ready depends only on registered state, never on out_ready
    assign bus.in_ready  = live_q && (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = data_q[rd_ptr_q];
    assign bus.out_tag   = tag_q[rd_ptr_q];
    assign bus.occupancy = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Next fill level; simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and fill level; reset discards everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            live_q   <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            count_q <= count_d;
            if (push) begin
                data_q[wr_ptr_q] <= perm_data;
                tag_q[wr_ptr_q]  <= bus.in_tag;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end
endmodule

// File: tb/tb_shift_rows_unit.sv
// Scoreboard bench for shift_rows_unit: an NB=4 instance under handshake traffic and an NB=8
// instance for the wider offset table.
module tb_shift_rows_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_rows_unit_if #(.NB(4), .TAG_W(4)) b4 ();
    shift_rows_unit_if #(.NB(8), .TAG_W(4)) b8 ();

    shift_rows_unit #(.NB(4), .TAG_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    shift_rows_unit #(.NB(8), .TAG_W(4)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    typedef struct {
        logic [0:127] data;
        logic [3:0]   tag;
    } sb_t;

    sb_t  exp_q [$];
    sb_t  head;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   n_pops  = 0;
    int   max_occ = 0;
    int   cyc     = 0;
    logic mon_en  = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: rotate each row one byte at a time, off(r) times
    function automatic logic [0:255] perm_model(input int nb, input logic inv,
                                                input logic [0:255] d);
        logic [7:0]   row [8];
        logic [7:0]   tmp;
        logic [0:255] o;
        int           off;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            off = (r < 2) ? r : ((nb == 8) ? r + 1 : r);
            for (int c = 0; c < nb; c++) row[c] = d[8*(4*c+r) +: 8];
            for (int k = 0; k < off; k++) begin
                if (!inv) begin
                    tmp = row[0];
                    for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
                    row[nb-1] = tmp;
                end else begin
                    tmp = row[nb-1];
                    for (int c = nb - 1; c > 0; c--) row[c] = row[c-1];
                    row[0] = tmp;
                end
            end
            for (int c = 0; c < nb; c++) o[8*(4*c+r) +: 8] = row[c];
        end
        return o;
    endfunction

    function automatic logic [0:127] model4(input logic inv, input logic [0:127] d);
        logic [0:255] t;
        t = perm_model(4, inv, {d, 128'b0});
        return t[0:127];
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: pop/compare on output handshakes, push expected on input handshakes
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (b4.out_valid && b4.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_output", 256'd1, 256'd0);
                end else begin
                    head = exp_q.pop_front();
                    check_val("sb_data", b4.out_data, head.data);
                    check_val("sb_tag", b4.out_tag, head.tag);
                end
                n_pops++;
            end
            if (b4.in_valid && b4.in_ready) begin
                exp_q.push_back('{data: model4(b4.in_inv, b4.in_data), tag: b4.in_tag});
            end
            if (int'(b4.occupancy) > max_occ) max_occ = int'(b4.occupancy);
        end
    end

    // Called at posedge+1; holds the block until the edge that accepts it, returns at edge+1
    task automatic send4(input logic inv, input logic [0:127] d, input logic [3:0] tag);
        int n;
        b4.in_valid = 1'b1;
        b4.in_inv   = inv;
        b4.in_data  = d;
        b4.in_tag   = tag;
        n = 0;
        while (!b4.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check_val("send_timeout", 256'd0, 256'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle4();
        b4.in_valid = 1'b0;
    endtask

    initial begin
        logic [0:127] a, b, c, z;
        logic [0:255] d8, e8;
        logic [0:255] got8;
        int           c0, p0, n, src3 [8];
        src3 = '{4, 5, 6, 7, 0, 1, 2, 3};

        rst_n = 1'b0;
        b4.in_valid = 1'b0; b4.in_inv = 1'b0; b4.in_tag = '0; b4.in_data = '0;
        b4.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.in_inv = 1'b0; b8.in_tag = '0; b8.in_data = '0;
        b8.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_occupancy", b4.occupancy, 0);
        check_val("rst_out_valid", b4.out_valid, 0);
        check_val("rst_in_ready", b4.in_ready, 0);
        check_val("rst_out_data", b4.out_data, 0);
        check_val("rst_out_tag", b4.out_tag, 0);

        rst_n = 1'b1;
        #1 check_val("ready_before_edge", b4.in_ready, 0);
        @(posedge clk); #1;
        check_val("ready_after_rst", b4.in_ready, 1);
        mon_en = 1'b1;

        // Known-answer, forward then inverse, one cycle latency
        send4(1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, 4'd5);
        idle4();
        check_val("kat_fwd_valid", b4.out_valid, 1);
        check_val("kat_fwd_data", b4.out_data, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        check_val("kat_fwd_tag", b4.out_tag, 4'd5);
        @(posedge clk); #1;
        send4(1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 4'd3);
        idle4();
        check_val("kat_inv_data", b4.out_data, 128'hd42711aee0bf98f1b8b45de51e415230);
        check_val("kat_inv_tag", b4.out_tag, 4'd3);
        repeat (2) @(posedge clk); #1;

        // Backpressure: three blocks offered, two fit
        b4.out_ready = 1'b0;
        a = rnd128(); b = rnd128(); c = rnd128();
        b4.in_valid = 1'b1; b4.in_inv = 1'b0; b4.in_data = a; b4.in_tag = 4'd1;
        @(posedge clk); #1;
        b4.in_inv = 1'b1; b4.in_data = b; b4.in_tag = 4'd2;
        @(posedge clk); #1;
        b4.in_inv = 1'b0; b4.in_data = c; b4.in_tag = 4'd3;
        @(posedge clk); #1;
        check_val("full_in_ready", b4.in_ready, 0);
        check_val("full_occupancy", b4.occupancy, 2);
        repeat (3) @(posedge clk); #1;
        check_val("stall_hold_data", b4.out_data, model4(1'b0, a));
        check_val("stall_hold_tag", b4.out_tag, 4'd1);
        check_val("stall_no_accept", exp_q.size(), 2);
        b4.out_ready = 1'b1;
        n = 0;
        while (!b4.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("ready_after_pop", b4.in_ready, 1);
        @(posedge clk); #1;
        idle4();
        repeat (3) @(posedge clk); #1;
        check_val("bp_drained", exp_q.size(), 0);

        // Alternating modes at full rate
        max_occ = 0;
        c0 = cyc;
        for (int i = 0; i < 8; i++) send4(i[0], rnd128(), 4'(i + 8));
        idle4();
        check_val("throughput_cycles", cyc - c0, 8);
        repeat (3) @(posedge clk); #1;
        check_val("alt_max_occ", max_occ, 1);
        check_val("alt_drained", exp_q.size(), 0);

        // Reset while full
        b4.out_ready = 1'b0;
        send4(1'b0, rnd128(), 4'd6);
        send4(1'b1, rnd128(), 4'd7);
        idle4();
        check_val("pre_rst_occ", b4.occupancy, 2);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", b4.out_valid, 0);
        check_val("midrst_occupancy", b4.occupancy, 0);
        check_val("midrst_out_data", b4.out_data, 0);
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        p0 = n_pops;
        b4.out_ready = 1'b1;
        z = rnd128();
        send4(1'b0, z, 4'd9);
        idle4();
        repeat (4) @(posedge clk); #1;
        check_val("post_rst_outputs", n_pops - p0, 1);
        check_val("post_rst_drained", exp_q.size(), 0);

        // NB=8: byte(r,c) = 8c+r
        d8 = '0;
        for (int cc = 0; cc < 8; cc++)
            for (int r = 0; r < 4; r++) d8[8*(4*cc+r) +: 8] = 8'(8 * cc + r);
        b8.in_valid = 1'b1; b8.in_inv = 1'b0; b8.in_data = d8; b8.in_tag = 4'd4;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        check_val("nb8_valid", b8.out_valid, 1);
        got8 = b8.out_data;
        for (int cc = 0; cc < 8; cc++)
            check_val($sformatf("nb8_row3_c%0d", cc), got8[8*(4*cc+3) +: 8], 8 * src3[cc] + 3);
        check_val("nb8_row2_c0", got8[8*2 +: 8], 8'd26);
        check_val("nb8_fwd_full", got8, perm_model(8, 1'b0, d8));
        check_val("nb8_tag", b8.out_tag, 4'd4);
        @(posedge clk); #1;
        e8 = {rnd128(), rnd128()};
        b8.in_valid = 1'b1; b8.in_inv = 1'b1; b8.in_data = e8; b8.in_tag = 4'd2;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        check_val("nb8_inv_full", b8.out_data, perm_model(8, 1'b1, e8));
        repeat (2) @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/shift_rows_unit.md
SHIFT_ROWS_UNIT -- requirements
Module: shift_rows_unit

Interface
REQ-001 The module SHALL have parameter NB, default 4, meaning state columns (Rijndael block = 32*NB bits); legal values 4, 6, 8.
REQ-002 The module SHALL have parameter TAG_W, default 4, meaning width of a sideband tag carried unchanged with each block.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: in_data/in_inv/in_tag hold a block.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the unit accepts a block this cycle.
REQ-007 The module SHALL have port in_inv, input, 1 bit: 0 = ShiftRows, 1 = InvShiftRows, per block.
REQ-008 The module SHALL have port in_tag, input, TAG_W bits: sideband tag.
REQ-009 The module SHALL have port in_data, input, [0:32*NB-1]: state, column-major; byte (r,c) occupies bits [8*(4c+r) : 8*(4c+r)+7].
REQ-010 The module SHALL have port out_valid, output, 1 bit: out_data/out_tag hold a result.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 The module SHALL have port out_tag, output, TAG_W bits: the tag of the result.
REQ-013 The module SHALL have port out_data, output, [0:32*NB-1]: the permuted state, same byte layout.
REQ-014 The module SHALL have port occupancy, output, 2 bits: number of buffered results (0..2).

Function
REQ-015 Shift offsets SHALL be row0 = 0, row1 = 1, row2 = NB==8 ? 3 : 2, row3 = NB==8 ? 4 : 3.
REQ-016 Forward mode SHALL compute out(r,c) = in(r,(c+off(r)) mod NB).
REQ-017 Inverse mode SHALL compute out(r,c) = in(r,(c-off(r)) mod NB).
REQ-018 The permutation SHALL be bytewise only; no bit inside a byte moves.
REQ-019 An NB value outside {4,6,8} SHALL cause an elaboration failure.
REQ-020 The unit SHALL contain a 2-entry FIFO of {permuted data, tag}; permutation is applied before the write.
REQ-021 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-022 Latency SHALL be 1 cycle: a block accepted at edge N is visible on out_data with out_valid=1 after edge N when the FIFO was empty.
REQ-023 in_ready SHALL equal (occupancy < 2) and be driven from registered state only, with no combinational path from out_ready.
REQ-024 out_valid SHALL equal (occupancy != 0); out_data/out_tag SHALL come from the head entry.
REQ-025 Simultaneous accept and pop SHALL leave occupancy unchanged and preserve order.
REQ-026 When full, in_ready SHALL be 0 and accept is impossible; pop frees a slot visible as in_ready=1 the next cycle.
REQ-027 Throughput SHALL be one block/cycle sustained while out_ready=1.
REQ-028 While out_valid=1 and out_ready=0, out_data/out_tag SHALL hold stable.
REQ-029 Read/write pointers SHALL be 1 bit and wrap 1->0.
REQ-030 in_inv SHALL be sampled per block; mixed-mode back-to-back blocks SHALL each use their own mode.

Reset
REQ-031 While rst_n=0, occupancy=0, out_valid=0, in_ready=0, out_data=0, out_tag=0, and both pointers=0.
REQ-032 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all buffered blocks immediately; no partial output is produced.

Verification
REQ-034 NB=4, fwd, in_data=d42711aee0bf98f1b8b45de51e415230, tag=5 -> next cycle out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_tag=5.
REQ-035 NB=4, inv, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=d42711aee0bf98f1b8b45de51e415230.
REQ-036 NB=8, fwd, byte(r,c)=8c+r -> row3 output bytes at c=0..7 are the input values of c=4,5,6,7,0,1,2,3; row2 c=0 holds input c=3.
REQ-037 out_ready=0, three blocks offered back-to-back -> two are accepted and in_ready=0 with occupancy=2; after out_ready=1 the blocks emerge in order.
REQ-038 Alternating fwd/inv blocks with out_ready=1 each cycle -> one result/cycle, each correct for its own mode, occupancy never exceeds 1.
REQ-039 Reset pulse with occupancy=2 -> out_valid=0 and occupancy=0 immediately; the next accepted block is the only output.
